// File: rtl/rst_seq_pkg.sv
// Shared types and defaults for the PLL-lock qualified reset sequencer.
package rst_seq_pkg;

  localparam int unsigned STATE_W                = 2;
  localparam int unsigned LOSS_CNT_W             = 8;
  localparam int unsigned LOCK_STABLE_CYCLES_DEF = 1024;
  localparam int unsigned RST_HOLD_CYCLES_DEF    = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_STABLE    = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; clears to 0 on reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/rst_seq.sv
// Core reset sequencer: qualifies PLL lock, holds core reset, then releases it
// and tracks lock losses.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYCLES = LOCK_STABLE_CYCLES_DEF,
  parameter int unsigned RST_HOLD_CYCLES    = RST_HOLD_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pll_lock,
  input  logic                  soft_rst_req,
  output logic                  core_rst_n,
  output logic                  ready,
  output logic [STATE_W-1:0]    state_o,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

  localparam int unsigned CNT_MAX = max_u(LOCK_STABLE_CYCLES, RST_HOLD_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD_CYCLES - 1);

  logic                  lock_s;
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;
  logic                  core_rst_n_q;
  logic                  lost;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pll_lock),
    .q_o   (lock_s)
  );

  // Next state: lock loss beats soft request, which beats counter expiry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lost    = 1'b0;
    case (state_q)
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
          lost    = 1'b1;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
          lost    = 1'b1;
        end else if (soft_rst_req) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
          lost    = 1'b1;
        end else if (soft_rst_req) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
    loss_d = (lost && (loss_q != '1)) ? loss_q + LOSS_CNT_W'(1) : loss_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_WAIT_LOCK;
      cnt_q        <= '0;
      loss_q       <= '0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      loss_q       <= loss_d;
      core_rst_n_q <= (state_d == ST_RUN);
    end
  end

  assign core_rst_n    = core_rst_n_q;
  assign ready         = core_rst_n_q;
  assign state_o       = state_q;
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq with LOCK_STABLE_CYCLES=8, RST_HOLD_CYCLES=4.
module tb_rst_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic       core_rst_n;
  logic       ready;
  logic [1:0] state_o;
  logic [7:0] lock_loss_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int exp_loss = 0;

  rst_seq #(
    .LOCK_STABLE_CYCLES (8),
    .RST_HOLD_CYCLES    (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pll_lock      (pll_lock),
    .soft_rst_req  (soft_rst_req),
    .core_rst_n    (core_rst_n),
    .ready         (ready),
    .state_o       (state_o),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({state_o, core_rst_n, ready, lock_loss_cnt} !== {2'd0, 1'b0, 1'b0, 8'd0}) begin
      n_errors++;
      $display("FAIL reset_values: got st=%0d rst=%b rdy=%b loss=%0d expected st=0 rst=0 rdy=0 loss=0",
               state_o, core_rst_n, ready, lock_loss_cnt);
    end
    tick(2);
    rst_n = 1'b1;
    exp_loss = 0;
  endtask

  // Expects pll_lock to be sampled high from the very next edge (E0).
  task automatic test_cold_start(input string tag);
    logic [1:0] exp_st;
    logic       exp_rst;
    pll_lock = 1'b1;
    for (int e = 0; e <= 14; e++) begin
      tick(1);
      exp_st  = (e < 2) ? 2'd0 : (e < 10) ? 2'd1 : (e < 14) ? 2'd2 : 2'd3;
      exp_rst = (e >= 14);
      n_checks++;
      if ({state_o, core_rst_n, ready} !== {exp_st, exp_rst, exp_rst}) begin
        n_errors++;
        $display("FAIL %s_E%0d: got st=%0d rst=%b rdy=%b expected st=%0d rst=%b rdy=%b",
                 tag, e, state_o, core_rst_n, ready, exp_st, exp_rst, exp_rst);
      end
    end
  endtask

  task automatic test_lock_loss_run();
    pll_lock = 1'b0;
    tick(2);
    n_checks++;
    if ({state_o, core_rst_n} !== {2'd3, 1'b1}) begin
      n_errors++;
      $display("FAIL loss_run_F1: got st=%0d rst=%b expected st=3 rst=1", state_o, core_rst_n);
    end
    tick(1);
    exp_loss++;
    n_checks++;
    if ({state_o, core_rst_n, lock_loss_cnt} !== {2'd0, 1'b0, 8'(exp_loss)}) begin
      n_errors++;
      $display("FAIL loss_run_F2: got st=%0d rst=%b loss=%0d expected st=0 rst=0 loss=%0d",
               state_o, core_rst_n, lock_loss_cnt, exp_loss);
    end
  endtask

  task automatic test_unstable();
    pll_lock = 1'b0;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    exp_loss = 0;
    pll_lock = 1'b1;
    tick(8);
    pll_lock = 1'b0;
    tick(2);
    n_checks++;
    if (state_o !== 2'd1) begin
      n_errors++;
      $display("FAIL unstable_E9: got st=%0d expected st=1", state_o);
    end
    tick(1);
    exp_loss = 1;
    n_checks++;
    if ({state_o, lock_loss_cnt} !== {2'd0, 8'd1}) begin
      n_errors++;
      $display("FAIL unstable_drop: got st=%0d loss=%0d expected st=0 loss=1", state_o, lock_loss_cnt);
    end
    pll_lock = 1'b1;
    tick(2);
    n_checks++;
    if (state_o !== 2'd0) begin
      n_errors++;
      $display("FAIL unstable_relock_E1: got st=%0d expected st=0", state_o);
    end
    tick(8);
    n_checks++;
    if (state_o !== 2'd1) begin
      n_errors++;
      $display("FAIL unstable_full_qual_E9: got st=%0d expected st=1", state_o);
    end
    tick(1);
    n_checks++;
    if (state_o !== 2'd2) begin
      n_errors++;
      $display("FAIL unstable_hold_E10: got st=%0d expected st=2", state_o);
    end
    tick(3);
    n_checks++;
    if ({state_o, core_rst_n} !== {2'd2, 1'b0}) begin
      n_errors++;
      $display("FAIL unstable_E13: got st=%0d rst=%b expected st=2 rst=0", state_o, core_rst_n);
    end
    tick(1);
    n_checks++;
    if ({state_o, core_rst_n} !== {2'd3, 1'b1}) begin
      n_errors++;
      $display("FAIL unstable_run_E14: got st=%0d rst=%b expected st=3 rst=1", state_o, core_rst_n);
    end
  endtask

  task automatic test_soft_reset();
    soft_rst_req = 1'b1;
    tick(1);
    soft_rst_req = 1'b0;
    n_checks++;
    if ({state_o, core_rst_n} !== {2'd2, 1'b0}) begin
      n_errors++;
      $display("FAIL soft_S0: got st=%0d rst=%b expected st=2 rst=0", state_o, core_rst_n);
    end
    tick(3);
    n_checks++;
    if ({state_o, core_rst_n} !== {2'd2, 1'b0}) begin
      n_errors++;
      $display("FAIL soft_S3: got st=%0d rst=%b expected st=2 rst=0", state_o, core_rst_n);
    end
    tick(1);
    n_checks++;
    if ({state_o, core_rst_n, ready} !== {2'd3, 1'b1, 1'b1}) begin
      n_errors++;
      $display("FAIL soft_S4: got st=%0d rst=%b rdy=%b expected st=3 rst=1 rdy=1", state_o, core_rst_n, ready);
    end
    soft_rst_req = 1'b1;
    tick(1);
    soft_rst_req = 1'b0;
    tick(2);
    soft_rst_req = 1'b1;
    tick(1);
    soft_rst_req = 1'b0;
    tick(1);
    n_checks++;
    if ({state_o, core_rst_n} !== {2'd2, 1'b0}) begin
      n_errors++;
      $display("FAIL soft_restart_S4: got st=%0d rst=%b expected st=2 rst=0", state_o, core_rst_n);
    end
    tick(2);
    n_checks++;
    if ({state_o, core_rst_n} !== {2'd2, 1'b0}) begin
      n_errors++;
      $display("FAIL soft_restart_S6: got st=%0d rst=%b expected st=2 rst=0", state_o, core_rst_n);
    end
    tick(1);
    n_checks++;
    if ({state_o, core_rst_n} !== {2'd3, 1'b1}) begin
      n_errors++;
      $display("FAIL soft_restart_S7: got st=%0d rst=%b expected st=3 rst=1", state_o, core_rst_n);
    end
  endtask

  task automatic test_simultaneous();
    pll_lock = 1'b0;
    tick(2);
    n_checks++;
    if (state_o !== 2'd3) begin
      n_errors++;
      $display("FAIL simul_F1: got st=%0d expected st=3", state_o);
    end
    soft_rst_req = 1'b1;
    tick(1);
    soft_rst_req = 1'b0;
    exp_loss++;
    n_checks++;
    if ({state_o, core_rst_n, lock_loss_cnt} !== {2'd0, 1'b0, 8'(exp_loss)}) begin
      n_errors++;
      $display("FAIL simul_priority: got st=%0d rst=%b loss=%0d expected st=0 rst=0 loss=%0d",
               state_o, core_rst_n, lock_loss_cnt, exp_loss);
    end
  endtask

  task automatic test_ignore_soft();
    soft_rst_req = 1'b1;
    tick(3);
    n_checks++;
    if (state_o !== 2'd0) begin
      n_errors++;
      $display("FAIL ignore_soft_wait: got st=%0d expected st=0", state_o);
    end
    pll_lock = 1'b1;
    tick(10);
    soft_rst_req = 1'b0;
    n_checks++;
    if (state_o !== 2'd1) begin
      n_errors++;
      $display("FAIL ignore_soft_stable_E9: got st=%0d expected st=1", state_o);
    end
    tick(1);
    n_checks++;
    if (state_o !== 2'd2) begin
      n_errors++;
      $display("FAIL ignore_soft_hold_E10: got st=%0d expected st=2", state_o);
    end
    tick(4);
    n_checks++;
    if ({state_o, core_rst_n} !== {2'd3, 1'b1}) begin
      n_errors++;
      $display("FAIL ignore_soft_run_E14: got st=%0d rst=%b expected st=3 rst=1", state_o, core_rst_n);
    end
  endtask

  task automatic test_glitch();
    #2;
    pll_lock = 1'b0;
    #3;
    pll_lock = 1'b1;
    tick(4);
    n_checks++;
    if ({state_o, lock_loss_cnt} !== {2'd3, 8'(exp_loss)}) begin
      n_errors++;
      $display("FAIL glitch_uncaptured: got st=%0d loss=%0d expected st=3 loss=%0d",
               state_o, lock_loss_cnt, exp_loss);
    end
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(1);
    n_checks++;
    if (state_o !== 2'd3) begin
      n_errors++;
      $display("FAIL glitch_captured_C1: got st=%0d expected st=3", state_o);
    end
    tick(1);
    exp_loss++;
    n_checks++;
    if ({state_o, lock_loss_cnt} !== {2'd0, 8'(exp_loss)}) begin
      n_errors++;
      $display("FAIL glitch_captured_C2: got st=%0d loss=%0d expected st=0 loss=%0d",
               state_o, lock_loss_cnt, exp_loss);
    end
    tick(13);
    n_checks++;
    if (state_o !== 2'd3) begin
      n_errors++;
      $display("FAIL glitch_requal: got st=%0d expected st=3", state_o);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      pll_lock = 1'b0;
      tick(3);
      exp_loss = (exp_loss >= 255) ? 255 : exp_loss + 1;
      n_checks++;
      if ({state_o, lock_loss_cnt} !== {2'd0, 8'(exp_loss)}) begin
        n_errors++;
        $display("FAIL saturation_ev%0d: got st=%0d loss=%0d expected st=0 loss=%0d",
                 i, state_o, lock_loss_cnt, exp_loss);
      end
      pll_lock = 1'b1;
      tick(3);
    end
    n_checks++;
    if (lock_loss_cnt !== 8'd255) begin
      n_errors++;
      $display("FAIL saturation_final: got loss=%0d expected loss=255", lock_loss_cnt);
    end
    tick(12);
    n_checks++;
    if ({state_o, core_rst_n} !== {2'd3, 1'b1}) begin
      n_errors++;
      $display("FAIL saturation_requal: got st=%0d rst=%b expected st=3 rst=1", state_o, core_rst_n);
    end
  endtask

  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({state_o, core_rst_n, ready, lock_loss_cnt} !== {2'd0, 1'b0, 1'b0, 8'd0}) begin
      n_errors++;
      $display("FAIL async_reset: got st=%0d rst=%b rdy=%b loss=%0d expected st=0 rst=0 rdy=0 loss=0",
               state_o, core_rst_n, ready, lock_loss_cnt);
    end
    #2;
    rst_n = 1'b1;
    exp_loss = 0;
    test_cold_start("rerun");
  endtask

  initial begin
    test_reset();
    test_cold_start("cold");
    test_lock_loss_run();
    test_unstable();
    test_soft_reset();
    test_simultaneous();
    test_ignore_soft();
    test_glitch();
    test_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
